inst_cache: RTL and testbench

Parametrised direct-mapped instruction cache with a line-refill state machine, sitting between each core's fetch stage and the shared memory interface of the multicore processor. Cache geometry is derived from the shared multicore package constants (instruction size, words per line, byte offset, word bits), extended with set count and address width. Supports single-cycle hits, multi-beat line refill and a whole-cache flush.

---
 rtl/inst_cache_pkg.sv | 23 ++
 rtl/inst_cache_if.sv | 33 +++
 rtl/inst_cache_array.sv | 55 +++++
 rtl/inst_cache.sv | 133 +++++++++++++
 tb/tb_inst_cache.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_cache_pkg.sv
// Shared multicore constants plus the instruction-cache geometry and FSM state type.
// Module parameters of the cache default to the values defined here.
package inst_cache_pkg;

    localparam int INST_SIZE      = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_SIZE      = INST_SIZE * WORDS_PER_LINE;
    localparam int OFFSET         = $clog2(INST_SIZE / 8);
    localparam int WORD_BITS      = $clog2(WORDS_PER_LINE);

    localparam int ADDR_SIZE      = 32;
    localparam int NUM_SETS       = 16;
    localparam int INDEX_BITS     = $clog2(NUM_SETS);
    localparam int TAG_BITS       = ADDR_SIZE - INDEX_BITS - WORD_BITS - OFFSET;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        RESPOND  = 2'd3
    } cache_state_t;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of one instruction cache.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the sender holds valid and its payload stable until then. resp_valid and
// mem_resp_valid are single-cycle pulses with no back-pressure.
interface inst_cache_if #(
    parameter int ADDR_SIZE = inst_cache_pkg::ADDR_SIZE,
    parameter int INST_SIZE = inst_cache_pkg::INST_SIZE
);

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_SIZE-1:0] req_addr;
    logic                 resp_valid;
    logic [INST_SIZE-1:0] resp_inst;
    logic                 flush;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ADDR_SIZE-1:0] mem_req_addr;
    logic                 mem_resp_valid;
    logic [INST_SIZE-1:0] mem_resp_data;

    // Fetch stage plus memory, seen from outside the cache.
    modport master (
        output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_inst, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_inst, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage of the direct-mapped cache: one asynchronous read port,
// one word write port, a tag+valid write and a bulk valid clear.
module inst_cache_array #(
    parameter int INST_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int NUM_SETS       = 16,
    parameter int TAG_BITS       = 23,
    parameter int INDEX_BITS     = $clog2(NUM_SETS),
    parameter int WORD_BITS      = $clog2(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [INST_SIZE-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [INST_SIZE-1:0]  wr_data,
    input  logic                  tag_we,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  clear_all
);

    logic [NUM_SETS-1:0]  valid_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
    logic [INST_SIZE-1:0] data_q [NUM_SETS][WORDS_PER_LINE];

    // A clear always beats a tag write landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_word] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: single-cycle hits, multi-beat line refill,
// whole-cache flush (deferred to the return to IDLE while a refill is in flight).
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INST_SIZE      = inst_cache_pkg::INST_SIZE,
    parameter int WORDS_PER_LINE = inst_cache_pkg::WORDS_PER_LINE,
    parameter int NUM_SETS       = inst_cache_pkg::NUM_SETS,
    parameter int ADDR_SIZE      = inst_cache_pkg::ADDR_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus,
    output cache_state_t dbg_state
);

    localparam int OFF_W   = $clog2(INST_SIZE / 8);
    localparam int WORD_W  = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_SIZE - INDEX_W - WORD_W - OFF_W;
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ADDR_SIZE'((64'd1 << (OFF_W + WORD_W)) - 64'd1);
    localparam logic [WORD_W-1:0]    LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    cache_state_t         state;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_W-1:0]    beat_cnt;
    logic                 flush_pending;
    logic                 resp_valid_q;
    logic [INST_SIZE-1:0] resp_inst_q;
    logic                 mem_req_valid_q;
    logic [ADDR_SIZE-1:0] mem_req_addr_q;

    logic [ADDR_SIZE-1:0] cur_addr;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [INST_SIZE-1:0] rd_data;
    logic                 hit;
    logic                 refill_we;
    logic                 tag_we;
    logic                 clear_all;
    logic                 unused_offset;

    // IDLE looks up the incoming request; every other state works on the captured line.
    assign cur_addr      = (state == IDLE) ? bus.req_addr : addr_q;
    assign unused_offset = ^cur_addr[OFF_W-1:0];
    assign hit           = rd_valid && (rd_tag == cur_addr[ADDR_SIZE-1 -: TAG_W]) && !bus.flush;
    assign refill_we     = (state == REFILL) && bus.mem_resp_valid;
    assign tag_we        = refill_we && (beat_cnt == LAST_BEAT) && !flush_pending && !bus.flush;
    assign clear_all     = ((state == IDLE) && bus.flush) ||
                           ((state == RESPOND) && (flush_pending || bus.flush));

    inst_cache_array #(
        .INST_SIZE      (INST_SIZE),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .NUM_SETS       (NUM_SETS),
        .TAG_BITS       (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (cur_addr[OFF_W+WORD_W +: INDEX_W]),
        .rd_word   (cur_addr[OFF_W +: WORD_W]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (refill_we),
        .wr_index  (addr_q[OFF_W+WORD_W +: INDEX_W]),
        .wr_word   (beat_cnt),
        .wr_data   (bus.mem_resp_data),
        .tag_we    (tag_we),
        .wr_tag    (addr_q[ADDR_SIZE-1 -: TAG_W]),
        .clear_all (clear_all)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            beat_cnt        <= '0;
            flush_pending   <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_inst_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                        if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= rd_data;
                        end else begin
                            state           <= MISS_REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= bus.req_addr & ~LINE_MASK;
                        end
                    end
                end
                MISS_REQ: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        beat_cnt        <= '0;
                        state           <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (bus.mem_resp_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) state <= RESPOND;
                    end
                end
                RESPOND: begin
                    resp_valid_q  <= 1'b1;
                    resp_inst_q   <= rd_data;
                    flush_pending <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_inst     = resp_inst_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a table of reads (hit/miss, refill data, flush
// placement) plus hand-written back-to-back and reset-mid-refill sequences.
module tb_inst_cache;
    import inst_cache_pkg::*;

    logic         clk;
    logic         rst;
    cache_state_t dbg_state;
    int           n_total;
    int           n_pass;

    inst_cache_if bus ();

    inst_cache dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        logic [31:0] line;
        logic [31:0] base;
        logic [31:0] exp;
        int          flush_beat;
        bit          flush_before;
        bit          flush_req;
    } vec_t;

    vec_t vecs[$];

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    task automatic do_read(input vec_t v, input string tag);
        bit quiet_ok;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = v.addr;
        bus.flush     = v.flush_req;
        check(bus.req_ready === 1'b1, {tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        if (!v.miss) begin
            check(bus.resp_valid === 1'b1, {tag, " hit resp_valid"}, 32'(bus.resp_valid), 32'd1);
            check(bus.resp_inst === v.exp, {tag, " hit resp_inst"}, bus.resp_inst, v.exp);
            check(bus.mem_req_valid === 1'b0, {tag, " hit mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        end else begin
            check(bus.resp_valid === 1'b0, {tag, " miss resp_valid"}, 32'(bus.resp_valid), 32'd0);
            check(bus.mem_req_valid === 1'b1, {tag, " mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
            check(bus.mem_req_addr === v.line, {tag, " mem_req_addr"}, bus.mem_req_addr, v.line);
            check(bus.req_ready === 1'b0, {tag, " req_ready miss"}, 32'(bus.req_ready), 32'd0);
            // Memory stalls one cycle: request must be held stable.
            @(negedge clk);
            check(bus.mem_req_valid === 1'b1 && bus.mem_req_addr === v.line,
                  {tag, " mem_req held"}, bus.mem_req_addr, v.line);
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check(bus.mem_req_valid === 1'b0, {tag, " mem_req dropped"}, 32'(bus.mem_req_valid), 32'd0);
            check(dbg_state === REFILL, {tag, " state refill"}, 32'(dbg_state), 32'(REFILL));
            quiet_ok = 1'b1;
            for (int b = 0; b < 8; b++) begin
                if (b == 2) begin
                    bus.mem_resp_valid = 1'b0;
                    @(negedge clk);
                end
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = v.base + 32'(b);
                bus.flush          = (b == v.flush_beat);
                @(negedge clk);
                if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) quiet_ok = 1'b0;
            end
            bus.mem_resp_valid = 1'b0;
            bus.flush          = 1'b0;
            check(quiet_ok, {tag, " quiet during refill"}, 32'(quiet_ok), 32'd1);
            check(dbg_state === RESPOND, {tag, " state respond"}, 32'(dbg_state), 32'(RESPOND));
            @(negedge clk);
            check(bus.resp_valid === 1'b1, {tag, " miss resp_valid"}, 32'(bus.resp_valid), 32'd1);
            check(bus.resp_inst === v.exp, {tag, " miss resp_inst"}, bus.resp_inst, v.exp);
            check(dbg_state === IDLE, {tag, " state idle"}, 32'(dbg_state), 32'(IDLE));
        end
        @(negedge clk);
        check(bus.resp_valid === 1'b0, {tag, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        bit   idle_ok;
        vec_t v;
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;

        //              addr          miss  line          base   exp    fbeat fbef freq
        vecs.push_back('{32'h0000_0104, 1'b1, 32'h0000_0100, 32'hA0, 32'hA1, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_011C, 1'b0, 32'h0,         32'h0,  32'hA7, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0100, 1'b0, 32'h0,         32'h0,  32'hA0, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0304, 1'b1, 32'h0000_0300, 32'hB0, 32'hB1, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0104, 1'b1, 32'h0000_0100, 32'hC0, 32'hC1, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0108, 1'b0, 32'h0,         32'h0,  32'hC2, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0304, 1'b1, 32'h0000_0300, 32'hD0, 32'hD1, -1, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_030C, 1'b0, 32'h0,         32'h0,  32'hD3, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0504, 1'b1, 32'h0000_0500, 32'hE0, 32'hE1,  3, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0504, 1'b1, 32'h0000_0500, 32'hF0, 32'hF1, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_030C, 1'b1, 32'h0000_0300, 32'h90, 32'h93, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0020, 1'b1, 32'h0000_0020, 32'h10, 32'h10, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_003C, 1'b0, 32'h0,         32'h0,  32'h17, -1, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFE0, 32'h20, 32'h27, -1, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFE0, 1'b0, 32'h0,         32'h0,  32'h20, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFF_FFE0, 1'b1, 32'h7FFF_FFE0, 32'h30, 32'h30, -1, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0308, 1'b1, 32'h0000_0300, 32'h50, 32'h52, -1, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFF_FFE4, 1'b1, 32'hFFFF_FFE0, 32'h40, 32'h41, -1, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(bus.req_ready === 1'b1, "reset req_ready", 32'(bus.req_ready), 32'd1);
        check(bus.resp_valid === 1'b0, "reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check(bus.resp_inst === 32'h0, "reset resp_inst", bus.resp_inst, 32'h0);
        check(bus.mem_req_valid === 1'b0, "reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check(bus.mem_req_addr === 32'h0, "reset mem_req_addr", bus.mem_req_addr, 32'h0);
        check(dbg_state === IDLE, "reset state", 32'(dbg_state), 32'(IDLE));

        foreach (vecs[i]) begin
            if (vecs[i].flush_before) begin
                @(negedge clk);
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
            do_read(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back hits, one per cycle.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hFFFF_FFE0;
        @(negedge clk);
        check(bus.resp_valid === 1'b1 && bus.resp_inst === 32'h40, "b2b first",
              bus.resp_inst, 32'h40);
        bus.req_addr = 32'hFFFF_FFE4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check(bus.resp_valid === 1'b1 && bus.resp_inst === 32'h41, "b2b second",
              bus.resp_inst, 32'h41);
        @(negedge clk);
        check(bus.resp_valid === 1'b0, "b2b end", 32'(bus.resp_valid), 32'd0);

        // Reset during refill beat 4; the remaining beats must be ignored.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0704;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check(bus.mem_req_addr === 32'h0000_0700, "rst seq mem_req_addr", bus.mem_req_addr, 32'h700);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h70 + 32'(b);
            @(negedge clk);
        end
        bus.mem_resp_data = 32'h74;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(dbg_state === IDLE, "rst mid-refill state", 32'(dbg_state), 32'(IDLE));
        check(bus.mem_req_valid === 1'b0, "rst mid-refill mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check(bus.resp_valid === 1'b0, "rst mid-refill resp_valid", 32'(bus.resp_valid), 32'd0);
        idle_ok = 1'b1;
        for (int b = 5; b < 8; b++) begin
            bus.mem_resp_data = 32'h70 + 32'(b);
            @(negedge clk);
            if (dbg_state !== IDLE || bus.resp_valid !== 1'b0) idle_ok = 1'b0;
        end
        bus.mem_resp_valid = 1'b0;
        check(idle_ok, "stray beats ignored", 32'(idle_ok), 32'd1);
        v = '{32'h0000_0704, 1'b1, 32'h0000_0700, 32'h80, 32'h81, -1, 1'b0, 1'b0};
        do_read(v, "after rst 0x704");
        v = '{32'h0000_0104, 1'b1, 32'h0000_0100, 32'h60, 32'h61, -1, 1'b0, 1'b0};
        do_read(v, "after rst 0x104");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
